i2s_mstr_tx: RTL and testbench
==============================

// Module: i2s_mstr_tx
// PURPOSE
//  I2S bus master transmitter: generates I2S_sclk/I2S_ws and serializes signed 24-bit left/right samples onto I2S_data.
//  Drives the I2S_Serf input pins of Equalizer in system benches, and serves as the audio output path to an external I2S DAC.
//  Samples arrive over a one-entry valid/ready buffer and are loaded once per frame.
// PARAMETERS
//  SCLK_DIV  16  clk cycles per sclk half-period; sclk = clk/(2*SCLK_DIV), legal 1..255
//  DATA_W    24  sample width (signed); must be <= SLOT_W
//  SLOT_W    32  sclk bits per channel slot; frame = 2*SLOT_W bits
// PORTS
//  clk        in   1       system clock (50MHz)
//  rst        in   1       asynchronous active-high reset
//  en         in   1       run enable
//  lft_smpl   in   DATA_W  left sample
//  rght_smpl  in   DATA_W  right sample
//  smpl_vld   in   1       sample pair valid
//  smpl_rdy   out  1       hold register empty; pair accepted when vld&rdy
//  I2S_sclk   out  1       bit clock
//  I2S_ws     out  1       word select, 0=left 1=right
//  I2S_data   out  1       serial data, MSB first
//  frm_strt   out  1       1-clk pulse when a frame is loaded
//  underrun   out  1       1-clk pulse when a frame is loaded with no new pair
// BEHAVIOUR
//  Reset: I2S_sclk=0, I2S_ws=1, I2S_data=0, smpl_rdy=1, frm_strt=0, underrun=0; hold empty, shift/last regs 0, state IDLE, bit_cnt=2*SLOT_W-2. Reset mid-frame aborts immediately; no partial bits resume.
//  States: IDLE (sclk held 0, divider cleared) -> RUN when en=1. RUN -> STOP when en=0; STOP completes the frame through bit_cnt=2*SLOT_W-1, then -> IDLE on the next fall event (no load, outputs to reset values, hold preserved). en=1 during STOP -> RUN, no gap.
//  Divider: counts 0..SCLK_DIV-1; sclk toggles on terminal count. fall_evt = cycle sclk registers 1->0. First rise SCLK_DIV clk after entering RUN, first fall_evt 2*SCLK_DIV clk after.
//  All of I2S_ws/I2S_data/bit_cnt update only on fall_evt (receiver samples on rising sclk). bit_cnt increments mod 2*SLOT_W; first fall_evt after IDLE gives 2*SLOT_W-1 (pad bit, ws=0) so ws leads the first MSB by one sclk.
//  I2S_ws = 1 for bit_cnt in [SLOT_W-1, 2*SLOT_W-2], else 0 (one-bit early transition per I2S).
//  I2S_data at bit_cnt n: n<DATA_W -> left[DATA_W-1-n]; SLOT_W<=n<SLOT_W+DATA_W -> right[DATA_W-1-(n-SLOT_W)]; else 0.
//  Load: on fall_evt giving bit_cnt=0: hold full -> shift regs <= hold, hold emptied, smpl_rdy=1 next clk, frm_strt pulse; hold empty -> reload last transmitted pair, frm_strt and underrun pulse.
//  Handshake: vld&rdy captures both channels into hold, smpl_rdy=0 next clk; rdy stays 0 until load. vld with hold full is ignored (source must hold). Accept and load in same cycle: load sees hold empty (underrun), incoming pair is captured for the next frame; no bypass.
//  Latency: accepted pair's left MSB appears on I2S_data at the next bit_cnt=0 fall_evt.
// CONFIGURATION
//  I2S_TX_UNDERRUN_MUTE_EN defined: underrun frame transmits zeros for both channels (last regs cleared); underrun pulse unchanged.
//  Not defined: underrun frame repeats the last transmitted pair.
// TESTING (SCLK_DIV=2, DATA_W=24, SLOT_W=32; sclk period 4 clk, frame 256 clk)
//  Reset asserted mid-frame -> next clk sclk=0, ws=1, data=0, smpl_rdy=1; with en held, restart shows first fall 4 clk after rst release+1.
//  en=1, push L=24'hA5C3F0, R=24'h800001 -> ws low one sclk before MSB; I2S_Serf in Equalizer captures lft_chnnl=24'hA5C3F0, rght_chnnl=24'h800001, vld pulses once per frame.
//  Pad check: bits 24..31 of each slot sample 0; ws rises at left bit 31, falls at right bit 31.
//  Starve after L=24'h123456: next frame underrun=1; data repeats 24'h123456 (mute build: 24'h000000).
//  Push pair on exact load cycle with hold empty -> underrun=1 that frame, pair sent next frame, smpl_rdy low 1 frame.
//  Drop en at left bit 10 -> frame completes all 64 bits, then sclk stays 0, ws=1; re-raise en -> pad bit then fresh frame.

Source files
------------

// File: rtl/i2s_mstr_tx_if.sv
// Sample-side handshake and I2S pin bundle for i2s_mstr_tx.
// master = transmitter side, slave = sample source / bus observer side.
interface i2s_mstr_tx_if #(
  parameter int DATA_W = 24
);
  logic              en;
  logic [DATA_W-1:0] lft_smpl;
  logic [DATA_W-1:0] rght_smpl;
  logic              smpl_vld;
  logic              smpl_rdy;
  logic              I2S_sclk;
  logic              I2S_ws;
  logic              I2S_data;
  logic              frm_strt;
  logic              underrun;

  modport master (
    input  en, lft_smpl, rght_smpl, smpl_vld,
    output smpl_rdy, I2S_sclk, I2S_ws, I2S_data, frm_strt, underrun
  );

  modport slave (
    output en, lft_smpl, rght_smpl, smpl_vld,
    input  smpl_rdy, I2S_sclk, I2S_ws, I2S_data, frm_strt, underrun
  );
endinterface

// File: rtl/i2s_mstr_tx.sv
// I2S master transmitter: divides clk into sclk/ws and serializes a one-entry buffered sample pair.
// Define I2S_TX_UNDERRUN_MUTE_EN to send silence on underrun instead of repeating the last pair.
module i2s_mstr_tx #(
  parameter int SCLK_DIV = 16,
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  i2s_mstr_tx_if.master bus
);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_W);
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] IDLE_BIT = CNT_W'(2 * SLOT_W - 2);
  localparam logic [CNT_W-1:0] WS_BEG   = CNT_W'(SLOT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, bit_nxt;
  logic              sclk_q, sclk_d, ws_q, ws_d, data_q, data_d;
  logic [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [DATA_W-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic              hold_full_q, hold_full_d;
  logic              frm_strt_q, frm_strt_d, underrun_q, underrun_d;
  logic              fall_evt, advance, hold_clr, accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_cnt_q   <= IDLE_BIT;
      sclk_q      <= 1'b0;
      ws_q        <= 1'b1;
      data_q      <= 1'b0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      last_l_q    <= '0;
      last_r_q    <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      frm_strt_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      sclk_q      <= sclk_d;
      ws_q        <= ws_d;
      data_q      <= data_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      frm_strt_q  <= frm_strt_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    sclk_d      = sclk_q;
    ws_d        = ws_q;
    data_d      = data_q;
    sh_l_d      = sh_l_q;
    sh_r_d      = sh_r_q;
    last_l_d    = last_l_q;
    last_r_d    = last_r_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    frm_strt_d  = 1'b0;
    underrun_d  = 1'b0;
    fall_evt    = 1'b0;
    advance     = 1'b0;
    hold_clr    = 1'b0;
    accept      = bus.smpl_vld & ~hold_full_q;
    bit_nxt     = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        div_d  = '0;
        sclk_d = 1'b0;
        if (bus.en) state_d = RUN;
      end
      default: begin
        if (div_q == DIV_TC) begin
          div_d    = '0;
          sclk_d   = ~sclk_q;
          fall_evt = sclk_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        if (state_q == RUN && !bus.en) state_d = STOP;
        else if (state_q == STOP && bus.en) state_d = RUN;
        // A stopping transmitter parks only at the frame boundary, never mid-frame.
        if (fall_evt) begin
          if (state_q == STOP && !bus.en && bit_cnt_q == LAST_BIT) begin
            state_d   = IDLE;
            ws_d      = 1'b1;
            data_d    = 1'b0;
            bit_cnt_d = IDLE_BIT;
          end else begin
            advance = 1'b1;
          end
        end
      end
    endcase

    if (advance) begin
      bit_cnt_d = bit_nxt;
      ws_d      = (bit_nxt >= WS_BEG) && (bit_nxt != LAST_BIT);
      if (bit_nxt == '0) begin
        frm_strt_d = 1'b1;
        if (hold_full_q) begin
          sh_l_d   = hold_l_q;
          sh_r_d   = hold_r_q;
          last_l_d = hold_l_q;
          last_r_d = hold_r_q;
          hold_clr = 1'b1;
        end else begin
          underrun_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
          sh_l_d   = '0;
          sh_r_d   = '0;
          last_l_d = '0;
          last_r_d = '0;
`else
          sh_l_d = last_l_q;
          sh_r_d = last_r_q;
`endif
        end
      end else begin
        if (int'(bit_nxt) < DATA_W) sh_l_d = sh_l_q << 1;
        if (int'(bit_nxt) > SLOT_W && int'(bit_nxt) < SLOT_W + DATA_W) sh_r_d = sh_r_q << 1;
      end
      if (int'(bit_nxt) < DATA_W) data_d = sh_l_d[DATA_W-1];
      else if (int'(bit_nxt) >= SLOT_W && int'(bit_nxt) < SLOT_W + DATA_W) data_d = sh_r_d[DATA_W-1];
      else data_d = 1'b0;
    end

    // A pair accepted on the load cycle is kept for the following frame.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = bus.lft_smpl;
      hold_r_d    = bus.rght_smpl;
    end else if (hold_clr) begin
      hold_full_d = 1'b0;
    end
  end

  assign bus.smpl_rdy = ~hold_full_q;
  assign bus.I2S_sclk = sclk_q;
  assign bus.I2S_ws   = ws_q;
  assign bus.I2S_data = data_q;
  assign bus.frm_strt = frm_strt_q;
  assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_i2s_mstr_tx.sv
// Directed bench for i2s_mstr_tx: table of sample pairs captured off the I2S pins, plus start/stop/reset sequences.
module tb_i2s_mstr_tx;
  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  i2s_mstr_tx_if #(.DATA_W(24)) bus ();

  i2s_mstr_tx #(.SCLK_DIV(2), .DATA_W(24), .SLOT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        push;
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    logic        exp_ur;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] exp_ws;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    int t = 0;
    bus.lft_smpl  = l;
    bus.rght_smpl = r;
    bus.smpl_vld  = 1'b1;
    while (!bus.smpl_rdy && t < 600) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.smpl_rdy) timeout("push_rdy");
    @(posedge clk); #1;
    bus.smpl_vld = 1'b0;
  endtask

  // Waits for a frame load, then samples data/ws on each of the 64 rising sclk edges.
  task automatic capture(input int drop_at, output logic [63:0] d, output logic [63:0] w,
                         output logic ur, output logic ok);
    int   t = 0;
    logic prev;
    d  = '0;
    w  = '0;
    ur = 1'b0;
    ok = 1'b0;
    while (!bus.frm_strt && t < 600) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.frm_strt) begin
      timeout("frm_strt");
      return;
    end
    ur = bus.underrun;
    for (int n = 0; n < 64; n++) begin
      t = 0;
      do begin
        prev = bus.I2S_sclk;
        @(posedge clk); #1;
        t++;
      end while (!(bus.I2S_sclk && !prev) && t < 20);
      if (!(bus.I2S_sclk && !prev)) begin
        timeout("sclk_rise");
        return;
      end
      d[63-n] = bus.I2S_data;
      w[63-n] = bus.I2S_ws;
      if (n == drop_at) bus.en = 1'b0;
    end
    ok = 1'b1;
  endtask

  task automatic check_frame(input string name, input int drop_at, input logic [23:0] el,
                             input logic [23:0] er, input logic eur);
    logic [63:0] d, w;
    logic        ur, ok;
    capture(drop_at, d, w, ur, ok);
    if (ok) begin
      chk({name, "_data"}, d, {el, 8'h00, er, 8'h00});
      chk({name, "_ws"}, w, exp_ws);
      chk({name, "_underrun"}, {63'd0, ur}, {63'd0, eur});
    end
  endtask

  task automatic measure_pad(input string name);
    int t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (bus.I2S_ws && t < 40);
    chk(name, t, 5);
  endtask

  initial begin
    int hi_cnt;
    int fs_cnt;

    for (int n = 0; n < 64; n++) exp_ws[63-n] = (n >= 31 && n <= 62);

    vecs[0] = '{1'b1, 24'hA5C3F0, 24'h800001, 24'hA5C3F0, 24'h800001, 1'b0};
    vecs[1] = '{1'b1, 24'h123456, 24'h654321, 24'h123456, 24'h654321, 1'b0};
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    vecs[2] = '{1'b0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1'b1};
`else
    vecs[2] = '{1'b0, 24'h000000, 24'h000000, 24'h123456, 24'h654321, 1'b1};
`endif
    vecs[3] = '{1'b1, 24'h7FFFFF, 24'h000000, 24'h7FFFFF, 24'h000000, 1'b0};
    vecs[4] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b0};
    vecs[5] = '{1'b1, 24'h000001, 24'h800000, 24'h000001, 24'h800000, 1'b0};

    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.smpl_vld  = 1'b0;
    bus.lft_smpl  = '0;
    bus.rght_smpl = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.I2S_sclk, bus.I2S_ws, bus.I2S_data, bus.smpl_rdy, bus.frm_strt, bus.underrun},
        6'b010100);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_no_en", {bus.I2S_sclk, bus.I2S_ws, bus.frm_strt}, 3'b010);

    bus.en = 1'b1;
    measure_pad("first_pad_edges");

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].push) push(vecs[i].l, vecs[i].r);
      check_frame($sformatf("vec%0d", i), -1, vecs[i].exp_l, vecs[i].exp_r, vecs[i].exp_ur);
    end

    // Pair offered exactly on the load cycle with the hold register empty.
    @(posedge clk); #1;
    push(24'h0F0F0F, 24'hF0F0F0);
    chk("rdy_after_load_push", {63'd0, bus.smpl_rdy}, 64'd0);
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    check_frame("load_cycle_ur", -1, 24'h000000, 24'h000000, 1'b1);
`else
    check_frame("load_cycle_ur", -1, 24'h000001, 24'h800000, 1'b1);
`endif
    check_frame("load_cycle_next", -1, 24'h0F0F0F, 24'hF0F0F0, 1'b0);
    chk("rdy_after_next", {63'd0, bus.smpl_rdy}, 64'd1);

    // Drop en mid-frame: the frame completes, then the bus parks.
    push(24'hC0FFEE, 24'h3579BD);
    check_frame("drop_frame", 10, 24'hC0FFEE, 24'h3579BD, 1'b0);
    repeat (2) @(posedge clk);
    hi_cnt = 0;
    fs_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.I2S_sclk) hi_cnt++;
      if (bus.frm_strt) fs_cnt++;
    end
    chk("parked_sclk_highs", hi_cnt, 0);
    chk("parked_frm_strt", fs_cnt, 0);
    chk("parked_ws_data", {bus.I2S_ws, bus.I2S_data}, 2'b10);

    push(24'h2468AC, 24'h13579B);
    bus.en = 1'b1;
    measure_pad("restart_pad_edges");
    check_frame("restart_frame", -1, 24'h2468AC, 24'h13579B, 1'b0);

    // Reset mid-frame with a pair waiting in the hold register.
    push(24'h111111, 24'h222222);
    push(24'h333333, 24'h444444);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("midframe_reset", {bus.I2S_sclk, bus.I2S_ws, bus.I2S_data, bus.smpl_rdy, bus.frm_strt, bus.underrun},
        6'b010100);
    @(posedge clk); #1;
    rst = 1'b0;
    measure_pad("post_reset_pad_edges");
    check_frame("post_reset_frame", -1, 24'h000000, 24'h000000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
